// File: rtl/mood_pkg.sv
// Shared constants for the mimosa mood-update path: direction encoding,
// default sizing and the fixed stimulus-source slot assignment.
package mood_pkg;

  localparam logic DIR_INC = 1'b1;
  localparam logic DIR_DEC = 1'b0;

  localparam int unsigned NREQ_DEFAULT     = 4;
  localparam int unsigned COOLDOWN_DEFAULT = 15;

  localparam int unsigned REQ_TOUCH = 0;
  localparam int unsigned REQ_LIGHT = 1;
  localparam int unsigned REQ_WATER = 2;
  localparam int unsigned REQ_DECAY = 3;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: the first set request at or after ptr+1,
// wrapping modulo N, wins. The pointer itself lives in the caller.
module rr_arbiter #(
  parameter int unsigned N  = 4,
  parameter int unsigned PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic          valid
);

  always_comb begin
    gnt   = '0;
    valid = 1'b0;
    // Walk offsets 1..N from the pointer; the first hit is the winner.
    for (int k = 1; k <= int'(N); k++) begin
      for (int i = 0; i < int'(N); i++) begin
        if (!valid && req[i] && (((int'(ptr) + k) % int'(N)) == i)) begin
          gnt[i] = 1'b1;
          valid  = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/mood_update_arbiter.sv
// Funnels inc/dec pulses from several stimulus sources into one saturating
// mood counter: per-source latching and cooldown, round-robin, set priority.
module mood_update_arbiter
  import mood_pkg::*;
#(
  parameter int unsigned NREQ     = NREQ_DEFAULT,
  parameter int unsigned COOLDOWN = COOLDOWN_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic [NREQ-1:0] req_inc,
  input  logic [NREQ-1:0] req_dec,
  input  logic            set_req,
  output logic            cnt_inc,
  output logic            cnt_dec,
  output logic            cnt_setval,
  output logic [NREQ-1:0] grant,
  output logic [NREQ-1:0] pending
);

  localparam int unsigned CDW = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;
  localparam int unsigned PW  = $clog2(NREQ);

  logic [NREQ-1:0]           pending_q, pending_d;
  logic [NREQ-1:0]           dir_q, dir_d;
  logic [NREQ-1:0]           grant_q, grant_d;
  logic [NREQ-1:0][CDW-1:0]  cd_q, cd_d;
  logic [PW-1:0]             ptr_q, ptr_d;
  logic                      cnt_inc_q, cnt_inc_d;
  logic                      cnt_dec_q, cnt_dec_d;
  logic                      cnt_setval_q, cnt_setval_d;

  logic [NREQ-1:0]           eligible;
  logic [NREQ-1:0]           arb_gnt;
  logic                      arb_valid;

  always_comb begin
    eligible = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      eligible[i] = pending_q[i] && (cd_q[i] == '0) && en && !set_req;
    end
  end

  rr_arbiter #(
    .N  (NREQ),
    .PW (PW)
  ) u_rr (
    .req   (eligible),
    .ptr   (ptr_q),
    .gnt   (arb_gnt),
    .valid (arb_valid)
  );

  always_comb begin
    pending_d    = pending_q & ~arb_gnt;
    dir_d        = dir_q;
    cd_d         = cd_q;
    ptr_d        = ptr_q;
    grant_d      = arb_gnt;
    cnt_inc_d    = arb_valid && |(arb_gnt & dir_q);
    cnt_dec_d    = arb_valid && |(arb_gnt & ~dir_q);
    cnt_setval_d = set_req;

    for (int i = 0; i < int'(NREQ); i++) begin
      if (arb_gnt[i]) begin
        cd_d[i] = CDW'(COOLDOWN);
        ptr_d   = PW'(i);
      end else if (cd_q[i] != '0) begin
        cd_d[i] = cd_q[i] - CDW'(1);
      end

      // Capture is judged against the post-grant state, so a request landing
      // on its own grant cycle becomes a fresh pending entry.
      if (req_inc[i] ^ req_dec[i]) begin
        if (!pending_d[i]) begin
          pending_d[i] = 1'b1;
          dir_d[i]     = req_inc[i] ? DIR_INC : DIR_DEC;
        end else if (dir_q[i] != req_inc[i]) begin
          pending_d[i] = 1'b0;
        end
      end
    end

    if (set_req) begin
      pending_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q    <= '0;
      dir_q        <= '0;
      grant_q      <= '0;
      cd_q         <= '0;
      ptr_q        <= PW'(NREQ - 1);
      cnt_inc_q    <= 1'b0;
      cnt_dec_q    <= 1'b0;
      cnt_setval_q <= 1'b0;
    end else begin
      pending_q    <= pending_d;
      dir_q        <= dir_d;
      grant_q      <= grant_d;
      cd_q         <= cd_d;
      ptr_q        <= ptr_d;
      cnt_inc_q    <= cnt_inc_d;
      cnt_dec_q    <= cnt_dec_d;
      cnt_setval_q <= cnt_setval_d;
    end
  end

  assign cnt_inc    = cnt_inc_q;
  assign cnt_dec    = cnt_dec_q;
  assign cnt_setval = cnt_setval_q;
  assign grant      = grant_q;
  assign pending    = pending_q;

endmodule

// File: tb/tb_mood_update_arbiter.sv
// Scoreboard bench for mood_update_arbiter: a cycle-level reference model
// queues expected outputs, an independent monitor pops and compares them.
module tb_mood_update_arbiter;
  import mood_pkg::*;

  localparam int NREQ     = NREQ_DEFAULT;
  localparam int COOLDOWN = COOLDOWN_DEFAULT;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic            en;
  logic            set_req;
  logic [NREQ-1:0] req_inc;
  logic [NREQ-1:0] req_dec;
  logic            cnt_inc;
  logic            cnt_dec;
  logic            cnt_setval;
  logic [NREQ-1:0] grant;
  logic [NREQ-1:0] pending;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  typedef struct packed {
    logic            setval;
    logic            inc;
    logic            dec;
    logic [NREQ-1:0] grant;
    logic [NREQ-1:0] pending;
  } obs_t;

  obs_t exp_q[$];

  // Reference state: per-source pending/direction/cooldown and last winner.
  bit m_pend[NREQ];
  bit m_dir[NREQ];
  int m_cd[NREQ];
  int m_last;

  mood_update_arbiter #(
    .NREQ     (NREQ),
    .COOLDOWN (COOLDOWN)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .req_inc    (req_inc),
    .req_dec    (req_dec),
    .set_req    (set_req),
    .cnt_inc    (cnt_inc),
    .cnt_dec    (cnt_dec),
    .cnt_setval (cnt_setval),
    .grant      (grant),
    .pending    (pending)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin : model
    obs_t e;
    int   w;
    int   idx;
    bit   nd;
    e = '0;
    w = -1;
    cyc++;
    if (!rst_n) begin
      for (int i = 0; i < NREQ; i++) begin
        m_pend[i] = 0;
        m_dir[i]  = 0;
        m_cd[i]   = 0;
      end
      m_last = NREQ - 1;
    end else begin
      if (en && !set_req) begin
        for (int k = 1; k <= NREQ; k++) begin
          idx = (m_last + k) % NREQ;
          if (w < 0 && m_pend[idx] && m_cd[idx] == 0) w = idx;
        end
      end
      e.setval = set_req;
      for (int i = 0; i < NREQ; i++) if (m_cd[i] > 0) m_cd[i]--;
      if (w >= 0) begin
        e.inc     = m_dir[w];
        e.dec     = !m_dir[w];
        e.grant   = NREQ'(1) << w;
        m_pend[w] = 0;
        m_cd[w]   = COOLDOWN;
        m_last    = w;
      end
      for (int i = 0; i < NREQ; i++) begin
        if (req_inc[i] != req_dec[i]) begin
          nd = req_inc[i];
          if (!m_pend[i]) begin
            m_pend[i] = 1;
            m_dir[i]  = nd;
          end else if (m_dir[i] != nd) begin
            m_pend[i] = 0;
          end
        end
      end
      if (set_req) for (int i = 0; i < NREQ; i++) m_pend[i] = 0;
      for (int i = 0; i < NREQ; i++) e.pending[i] = m_pend[i];
    end
    exp_q.push_back(e);
  end

  initial begin : monitor
    obs_t e;
    obs_t a;
    forever begin
      @(posedge clk);
      #1;
      a.setval  = cnt_setval;
      a.inc     = cnt_inc;
      a.dec     = cnt_dec;
      a.grant   = grant;
      a.pending = pending;
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL scoreboard empty at cycle %0d", cyc);
      end else begin
        e = exp_q.pop_front();
        if (a !== e) begin
          miscompares++;
          $display("FAIL outputs cycle %0d: got set=%b inc=%b dec=%b grant=%b pend=%b, want set=%b inc=%b dec=%b grant=%b pend=%b",
                   cyc, a.setval, a.inc, a.dec, a.grant, a.pending,
                   e.setval, e.inc, e.dec, e.grant, e.pending);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #3;
  endtask

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  initial begin : driver
    int n;
    int r;
    logic [NREQ-1:0] ri;
    logic [NREQ-1:0] rd;
    en      = 1'b1;
    set_req = 1'b0;
    req_inc = '0;
    req_dec = '0;
    #1 rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // Round-robin from reset: requester 0 first, then in order.
    req_dec = '1;
    tick();
    req_dec = '0;
    tick();
    check("rr first grant", int'(grant), 1);
    check("rr first dec", int'(cnt_dec), 1);
    tick();
    check("rr second grant", int'(grant), 2);
    tick();
    check("rr third grant", int'(grant), 4);
    tick();
    check("rr fourth grant", int'(grant), 8);
    req_inc[REQ_TOUCH] = 1'b1;
    req_inc[REQ_DECAY] = 1'b1;
    tick();
    req_inc = '0;
    repeat (COOLDOWN + 4) tick();

    // Single request latency and cooldown on a repeat.
    req_inc[REQ_WATER] = 1'b1;
    tick();
    req_inc = '0;
    check("single pending", int'(pending), 4);
    tick();
    check("single inc", int'(cnt_inc), 1);
    check("single grant", int'(grant), 4);
    tick();
    check("single one-shot", int'(cnt_inc), 0);
    check("single cleared", int'(pending), 0);
    req_inc[REQ_WATER] = 1'b1;
    tick();
    req_inc = '0;
    repeat (COOLDOWN + 4) tick();

    // Cancel, duplicate and simultaneous inc+dec on requester 1.
    en = 1'b0;
    req_inc[REQ_LIGHT] = 1'b1;
    tick();
    req_inc = '0;
    req_dec[REQ_LIGHT] = 1'b1;
    tick();
    req_dec = '0;
    check("cancel pending", int'(pending), 0);
    en = 1'b1;
    n = 0;
    repeat (4) begin tick(); n += int'(cnt_inc | cnt_dec); end
    check("cancel no strobe", n, 0);
    en = 1'b0;
    req_inc[REQ_LIGHT] = 1'b1;
    tick();
    tick();
    req_inc = '0;
    en = 1'b1;
    n = 0;
    repeat (COOLDOWN + 4) begin tick(); n += int'(cnt_inc); end
    check("duplicate one strobe", n, 1);
    req_inc[REQ_LIGHT] = 1'b1;
    req_dec[REQ_LIGHT] = 1'b1;
    tick();
    req_inc = '0;
    req_dec = '0;
    check("both dirs ignored", int'(pending), 0);

    // set_req beats eligible pending requests.
    en = 1'b0;
    req_inc[REQ_TOUCH] = 1'b1;
    req_dec[REQ_LIGHT] = 1'b1;
    tick();
    req_inc = '0;
    req_dec = '0;
    check("set pre pending", int'(pending), 3);
    en = 1'b1;
    set_req = 1'b1;
    tick();
    set_req = 1'b0;
    check("set strobe", int'(cnt_setval), 1);
    check("set no inc/dec", int'({cnt_inc, cnt_dec}), 0);
    check("set no grant", int'(grant), 0);
    check("set clears pending", int'(pending), 0);
    tick();
    check("set one cycle", int'(cnt_setval), 0);

    // en low holds pending without granting.
    en = 1'b0;
    req_dec[REQ_DECAY] = 1'b1;
    tick();
    req_dec = '0;
    n = 0;
    repeat (20) begin tick(); n += int'(cnt_inc | cnt_dec); end
    check("en low no strobe", n, 0);
    check("en low held", int'(pending), 8);
    en = 1'b1;
    tick();
    check("en release dec", int'(cnt_dec), 1);
    check("en release grant", int'(grant), 8);
    repeat (COOLDOWN + 2) tick();

    // Reset during the strobe cycle.
    req_inc[REQ_TOUCH] = 1'b1;
    tick();
    req_inc = '0;
    tick();
    check("pre-reset strobe", int'(cnt_inc), 1);
    rst_n = 1'b0;
    #1;
    check("reset clears outputs",
          int'({cnt_inc, cnt_dec, cnt_setval, grant, pending}), 0);
    tick();
    tick();
    rst_n = 1'b1;
    req_inc[REQ_TOUCH] = 1'b1;
    req_inc[REQ_DECAY] = 1'b1;
    tick();
    req_inc = '0;
    tick();
    check("post-reset first", int'(grant), 1);
    tick();
    check("post-reset second", int'(grant), 8);

    // Random traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      ri = '0;
      rd = '0;
      for (int i = 0; i < NREQ; i++) begin
        r = int'($urandom_range(0, 15));
        if (r == 0 || r == 2) ri[i] = 1'b1;
        if (r == 1 || r == 2) rd[i] = 1'b1;
      end
      req_inc = ri;
      req_dec = rd;
      en      = ($urandom_range(0, 7) != 0);
      set_req = ($urandom_range(0, 31) == 0);
      tick();
    end
    req_inc = '0;
    req_dec = '0;
    set_req = 1'b0;
    repeat (3) tick();
    check("scoreboard drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
